// File: rtl/mult8_seq_ctrl_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
// Imported by the control block and its add/sub stage.
package mult_pkg;

    localparam int N = 8;
    localparam logic [2:0] LAST_ITER = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADD,
        SHIFT,
        HOLD
    } state_t;

endpackage

// File: rtl/add_sub.sv
// 9-bit add/sub stage: A +/- S with both operands sign-extended.
// Sub selects two's-complement negation of S.
module add_sub
    import mult_pkg::*;
(
    input  logic [N-1:0] A,
    input  logic [N-1:0] S,
    input  logic         Sub,
    output logic [N:0]   Sum
);

    logic [N:0] a_ext;
    logic [N:0] s_ext;
    logic [N:0] s_op;

    // Sign-extend both operands and negate S on subtract
    always_comb begin
        a_ext = {A[N-1], A};
        s_ext = {S[N-1], S};
        s_op  = Sub ? (~s_ext + 9'd1) : s_ext;
        Sum   = a_ext + s_op;
    end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential two's-complement shift-add multiplier control.
// Owns X/A/B/S registers and the IDLE..HOLD FSM.
module mult8_seq_ctrl
    import mult_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Run,
    input  logic         ClearA_LoadB,
    input  logic [N-1:0] Sw,
    output logic [N-1:0] Aval,
    output logic [N-1:0] Bval,
    output logic         Xval,
    output logic         Done
);

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  s_q, s_d;
    logic          x_q, x_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          sub;
    logic [N:0]    sum;

    // Final iteration subtracts to weight a negative multiplier's MSB
    assign sub = (cnt_q == LAST_ITER);

    add_sub u_add_sub (
        .A   (a_q),
        .S   (s_q),
        .Sub (sub),
        .Sum (sum)
    );

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            x_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            x_q   <= x_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-state and datapath update; Run has priority over load in IDLE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (Run) begin
                    state_d = START;
                end else if (ClearA_LoadB) begin
                    a_d = '0;
                    x_d = 1'b0;
                    b_d = Sw;
                end
            end
            START: begin
                a_d     = '0;
                x_d     = 1'b0;
                s_d     = Sw;
                cnt_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                if (b_q[0]) {x_d, a_d} = sum;
                state_d = SHIFT;
            end
            SHIFT: begin
                {x_d, a_d, b_d} = {x_q, x_q, a_q, b_q[N-1:1]};
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == LAST_ITER) ? HOLD : ADD;
            end
            HOLD: begin
                if (!Run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign Xval = x_q;
    assign Done = (state_q == HOLD);

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed self-checking bench for mult8_seq_ctrl.
// Expected values are hand-computed products.
module tb_mult8_seq_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] Sw;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       Done;

    int n_chk;
    int n_fail;

    mult8_seq_ctrl dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .Sw           (Sw),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .Done         (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_b(input logic [7:0] v);
        ClearA_LoadB = 1'b1;
        Sw = v;
        tick(1);
        ClearA_LoadB = 1'b0;
    endtask

    task automatic mult(input logic [7:0] s);
        Run = 1'b1;
        Sw = s;
        tick(18);
    endtask

    task automatic chk_res(input string tag, input logic [16:0] exp);
        chk({tag, "_done"}, {15'd0, Done}, 16'd1);
        chk({tag, "_xab"}, {7'd0, Xval, Aval, Bval}, {7'd0, exp[16:8], exp[7:0]});
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        Reset_n = 1'b0;
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        Sw = 8'h00;
        tick(2);
        chk("rst_a", {8'd0, Aval}, 16'h0000);
        chk("rst_b", {8'd0, Bval}, 16'h0000);
        chk("rst_x", {15'd0, Xval}, 16'h0000);
        chk("rst_done", {15'd0, Done}, 16'h0000);
        Reset_n = 1'b1;
        tick(1);

        load_b(8'h3B);
        chk("load_b", {8'd0, Bval}, 16'h003B);

        Run = 1'b1;
        Sw = 8'h07;
        tick(2);
        Sw = 8'hAA;
        tick(15);
        chk("lat17", {15'd0, Done}, 16'd0);
        tick(1);
        chk_res("p59x7", {1'b0, 16'h019D});

        tick(22);
        chk_res("hold_run", {1'b0, 16'h019D});
        ClearA_LoadB = 1'b1;
        Sw = 8'h55;
        tick(2);
        ClearA_LoadB = 1'b0;
        chk_res("hold_clr", {1'b0, 16'h019D});
        Run = 1'b0;
        tick(1);
        chk("idle_done", {15'd0, Done}, 16'd0);

        mult(8'h02);
        chk_res("consec", {1'b1, 16'hFF3A});
        Run = 1'b0;
        tick(1);

        load_b(8'h3B);
        mult(8'hF9);
        chk_res("n7x59", {1'b1, 16'hFE63});
        Run = 1'b0;
        tick(1);

        load_b(8'hF8);
        mult(8'hF8);
        chk_res("n8xn8", {1'b0, 16'h0040});
        Run = 1'b0;
        tick(1);

        load_b(8'h80);
        mult(8'h80);
        chk_res("n128sq", {1'b0, 16'h4000});
        Run = 1'b0;
        tick(1);

        load_b(8'h55);
        chk("clr_xab", {7'd0, Xval, Aval, Bval}, 16'h0055);

        Run = 1'b1;
        ClearA_LoadB = 1'b1;
        Sw = 8'h11;
        tick(1);
        ClearA_LoadB = 1'b0;
        chk("both_b", {8'd0, Bval}, 16'h0055);
        tick(17);
        chk_res("p85x17", {1'b0, 16'h05A5});
        Run = 1'b0;
        tick(1);

        load_b(8'h3B);
        Run = 1'b1;
        Sw = 8'h07;
        tick(8);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_xab", {7'd0, Xval, Aval, Bval}, 16'h0000);
        chk("arst_done", {15'd0, Done}, 16'd0);
        Run = 1'b0;
        #2 Reset_n = 1'b1;
        tick(3);
        chk("post_rst", {6'd0, Done, Xval, Aval, Bval}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
